// File: rtl/uart.sv
// UART with 16x oversampled RX, TX FSM and 16-deep FIFOs on both sides.
// Ports: clk, reset (async low), rd_uart/wr_uart/w_data/rx in; tx, flags, rd_data out.
// Optional: define UART_PARITY_EN for 8E1 frames (PARITY state in both FSMs).

module uart_fifo #(
  parameter int W  = 8,
  parameter int AW = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr,
  input  logic         rd,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  logic [W-1:0]  mem [2**AW];
  logic [AW-1:0] wptr, rptr;
  logic [AW-1:0] wnext, rnext;
  logic          wr_en, rd_en;

  // A push while full is accepted only alongside a pop.
  assign wr_en = wr && (!full || rd);
  assign rd_en = rd && !empty;
  assign wnext = wptr + 1'b1;
  assign rnext = rptr + 1'b1;
  assign dout  = mem[rptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr] <= din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (wr_en) wptr <= wnext;
      if (rd_en) rptr <= rnext;
      unique case (1'b1)
        wr_en && !rd_en: begin
          empty <= 1'b0;
          full  <= (wnext == rptr);
        end
        rd_en && !wr_en: begin
          full  <= 1'b0;
          empty <= (rnext == wptr);
        end
        default: ;
      endcase
    end
  end

endmodule

module uart #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int DVSR    = 326,
  parameter int FIFO_W  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rd_uart,
  input  logic       wr_uart,
  input  logic       rx,
  input  logic [7:0] w_data,
  output logic       tx,
  output logic       tx_full,
  output logic       tx_empty,
  output logic       rx_full,
  output logic       rx_empty,
  output logic [7:0] rd_data
);

  localparam int CW = (DVSR > 1) ? $clog2(DVSR) : 1;
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } st_t;
`else
  typedef enum logic [1:0] {
    IDLE, START, DATA, STOP
  } st_t;
`endif

  // ---- oversample tick ----
  logic [CW-1:0] tick_cnt;
  logic          tick;

  assign tick = (tick_cnt == CW'(DVSR - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 1'b1;
  end

  // ---- RX ----
  logic [1:0]      rx_sync;
  logic            rx_s;
  st_t             rx_st;
  logic [4:0]      rx_sc;
  logic [NW-1:0]   rx_n;
  logic [DBIT-1:0] rx_b;
  logic            rx_push;
  logic [7:0]      rx_head;
`ifdef UART_PARITY_EN
  logic            rx_perr;
`endif

  assign rx_s = rx_sync[1];

  // Line idles high, so the synchronizer resets to 1s.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rx_sync <= 2'b11;
    else        rx_sync <= {rx_sync[0], rx};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_st   <= IDLE;
      rx_sc   <= '0;
      rx_n    <= '0;
      rx_b    <= '0;
      rx_push <= 1'b0;
`ifdef UART_PARITY_EN
      rx_perr <= 1'b0;
`endif
    end else begin
      rx_push <= 1'b0;
      unique case (rx_st)
        IDLE: begin
          if (!rx_s) begin
            rx_st <= START;
            rx_sc <= '0;
          end
        end
        START: begin
          if (tick) begin
            if (rx_sc == 5'd7) begin
              rx_sc <= '0;
              rx_n  <= '0;
              rx_st <= rx_s ? IDLE : DATA;
            end else begin
              rx_sc <= rx_sc + 1'b1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (rx_sc == 5'd15) begin
              rx_sc <= '0;
              rx_b  <= {rx_s, rx_b[DBIT-1:1]};
              if (rx_n == NW'(DBIT - 1)) begin
`ifdef UART_PARITY_EN
                rx_st <= PARITY;
`else
                rx_st <= STOP;
`endif
              end else begin
                rx_n <= rx_n + 1'b1;
              end
            end else begin
              rx_sc <= rx_sc + 1'b1;
            end
          end
        end
`ifdef UART_PARITY_EN
        PARITY: begin
          if (tick) begin
            if (rx_sc == 5'd15) begin
              rx_sc   <= '0;
              rx_perr <= ^{rx_b, rx_s};
              rx_st   <= STOP;
            end else begin
              rx_sc <= rx_sc + 1'b1;
            end
          end
        end
`endif
        STOP: begin
          if (tick) begin
            if (rx_sc == 5'(SB_TICK - 1)) begin
              rx_st <= IDLE;
`ifdef UART_PARITY_EN
              rx_push <= rx_s && !rx_perr;
`else
              rx_push <= rx_s;
`endif
            end else begin
              rx_sc <= rx_sc + 1'b1;
            end
          end
        end
        default: rx_st <= IDLE;
      endcase
    end
  end

  uart_fifo #(.W(8), .AW(FIFO_W)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .wr    (rx_push),
    .rd    (rd_uart),
    .din   (8'(rx_b)),
    .dout  (rx_head),
    .full  (rx_full),
    .empty (rx_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                    rd_data <= 8'h00;
    else if (rd_uart && !rx_empty) rd_data <= rx_head;
  end

  // ---- TX ----
  st_t             tx_st;
  logic [4:0]      tx_sc;
  logic [NW-1:0]   tx_n;
  logic [DBIT-1:0] tx_b;
  logic            tx_reg;
  logic            tx_pop;
  logic [7:0]      tx_head;
`ifdef UART_PARITY_EN
  logic            tx_par;
`endif

  // Head is consumed the same cycle the FSM latches it.
  assign tx_pop = (tx_st == IDLE) && !tx_empty;
  assign tx     = tx_reg;

  uart_fifo #(.W(8), .AW(FIFO_W)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .wr    (wr_uart),
    .rd    (tx_pop),
    .din   (w_data),
    .dout  (tx_head),
    .full  (tx_full),
    .empty (tx_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_st  <= IDLE;
      tx_sc  <= '0;
      tx_n   <= '0;
      tx_b   <= '0;
      tx_reg <= 1'b1;
`ifdef UART_PARITY_EN
      tx_par <= 1'b0;
`endif
    end else begin
      unique case (tx_st)
        IDLE: begin
          tx_reg <= 1'b1;
          if (!tx_empty) begin
            tx_b   <= tx_head[DBIT-1:0];
`ifdef UART_PARITY_EN
            tx_par <= ^tx_head[DBIT-1:0];
`endif
            tx_sc  <= '0;
            tx_reg <= 1'b0;
            tx_st  <= START;
          end
        end
        START: begin
          if (tick) begin
            if (tx_sc == 5'd15) begin
              tx_sc  <= '0;
              tx_n   <= '0;
              tx_reg <= tx_b[0];
              tx_st  <= DATA;
            end else begin
              tx_sc <= tx_sc + 1'b1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (tx_sc == 5'd15) begin
              tx_sc <= '0;
              tx_b  <= tx_b >> 1;
              if (tx_n == NW'(DBIT - 1)) begin
`ifdef UART_PARITY_EN
                tx_reg <= tx_par;
                tx_st  <= PARITY;
`else
                tx_reg <= 1'b1;
                tx_st  <= STOP;
`endif
              end else begin
                tx_n   <= tx_n + 1'b1;
                tx_reg <= tx_b[1];
              end
            end else begin
              tx_sc <= tx_sc + 1'b1;
            end
          end
        end
`ifdef UART_PARITY_EN
        PARITY: begin
          if (tick) begin
            if (tx_sc == 5'd15) begin
              tx_sc  <= '0;
              tx_reg <= 1'b1;
              tx_st  <= STOP;
            end else begin
              tx_sc <= tx_sc + 1'b1;
            end
          end
        end
`endif
        STOP: begin
          if (tick) begin
            if (tx_sc == 5'(SB_TICK - 1)) begin
              tx_st <= IDLE;
            end else begin
              tx_sc <= tx_sc + 1'b1;
            end
          end
        end
        default: tx_st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart.sv
// Self-checking bench for uart, run with a short DVSR.
// Table vectors for single frames plus hand sequences for corner cases.

module tb_uart;

  localparam int DVSR = 4;
  localparam int BIT  = 16 * DVSR;
`ifdef UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rd_uart = 1'b0;
  logic       wr_uart = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] w_data = 8'h00;
  logic       tx;
  logic       tx_full, tx_empty, rx_full, rx_empty;
  logic [7:0] rd_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart #(.DVSR(DVSR)) dut (
    .clk      (clk),
    .reset    (reset),
    .rd_uart  (rd_uart),
    .wr_uart  (wr_uart),
    .rx       (rx),
    .w_data   (w_data),
    .tx       (tx),
    .tx_full  (tx_full),
    .tx_empty (tx_empty),
    .rx_full  (rx_full),
    .rx_empty (rx_empty),
    .rd_data  (rd_data)
  );

  typedef struct {
    bit         is_tx;
    logic [7:0] data;
    logic [9:0] frame;
    bit         exp_push;
  } vec_t;

  vec_t vt [6];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // frame bit i is the i-th bit on the line (start at bit 0)
  function automatic logic [10:0] seq_of(input logic [9:0] f);
    logic [10:0] s;
    s = '0;
    s[8:0] = f[8:0];
`ifdef UART_PARITY_EN
    s[9]  = ^f[8:1];
    s[10] = f[9];
`else
    s[9] = f[9];
`endif
    return s;
  endfunction

  function automatic logic [9:0] frame_of(input logic [7:0] d);
    return {1'b1, d, 1'b0};
  endfunction

  task automatic write_byte(input logic [7:0] d);
    @(negedge clk);
    wr_uart = 1'b1;
    w_data  = d;
    @(negedge clk);
    wr_uart = 1'b0;
  endtask

  task automatic read_byte;
    @(negedge clk);
    rd_uart = 1'b1;
    @(negedge clk);
    rd_uart = 1'b0;
  endtask

  // A zero stop bit is shortened so the line is high again before
  // the receiver's next mid-start sample.
  task automatic drive_rx(input logic [10:0] s);
    for (int i = 0; i < NB; i++) begin
      rx = s[i];
      if (i == NB - 1 && !s[i]) repeat (3 * BIT / 4) @(negedge clk);
      else                      repeat (BIT) @(negedge clk);
    end
    rx = 1'b1;
  endtask

  task automatic capture_tx(input int max_wait, output logic [10:0] got,
                            output bit ok);
    int w;
    w = 0;
    got = '0;
    while (tx !== 1'b0 && w < max_wait) begin
      @(negedge clk);
      w++;
    end
    ok = (tx === 1'b0);
    if (ok) begin
      repeat (BIT / 2) @(negedge clk);
      for (int i = 0; i < NB; i++) begin
        got[i] = tx;
        if (i < NB - 1) repeat (BIT) @(negedge clk);
      end
    end
  endtask

  logic [10:0] got_f;
  bit          ok_f;
  int          lows;

  initial begin
    vt[0] = '{1'b1, 8'hA5, 10'b1101001010, 1'b1};
    vt[1] = '{1'b1, 8'h00, 10'b1000000000, 1'b1};
    vt[2] = '{1'b1, 8'hFF, 10'b1111111110, 1'b1};
    vt[3] = '{1'b0, 8'h3C, 10'b1001111000, 1'b1};
    vt[4] = '{1'b0, 8'hA5, 10'b1101001010, 1'b1};
    vt[5] = '{1'b0, 8'h81, 10'b0100000010, 1'b0};

    // reset
    #50;
    check("rst_tx",       32'(tx),       32'd1);
    check("rst_tx_empty", 32'(tx_empty), 32'd1);
    check("rst_rx_empty", 32'(rx_empty), 32'd1);
    check("rst_tx_full",  32'(tx_full),  32'd0);
    check("rst_rx_full",  32'(rx_full),  32'd0);
    check("rst_rd_data",  32'(rd_data),  32'h00);
    #50;
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check("post_rst_tx",       32'(tx),       32'd1);
    check("post_rst_tx_empty", 32'(tx_empty), 32'd1);
    check("post_rst_rx_empty", 32'(rx_empty), 32'd1);

    // table vectors
    for (int i = 0; i < 6; i++) begin
      if (vt[i].is_tx) begin
        write_byte(vt[i].data);
        repeat (2) @(negedge clk);
        check("tx_empty_after_load", 32'(tx_empty), 32'd1);
        capture_tx(4 * BIT, got_f, ok_f);
        check("tx_start_seen", 32'(ok_f), 32'd1);
        check("tx_frame", 32'(got_f), 32'(seq_of(vt[i].frame)));
        repeat (BIT) @(negedge clk);
      end else begin
        drive_rx(seq_of(vt[i].frame));
        repeat (8) @(negedge clk);
        check("rx_empty_after_frame", 32'(rx_empty),
              32'(!vt[i].exp_push));
        if (vt[i].exp_push) begin
          read_byte();
          check("rx_rd_data", 32'(rd_data), 32'(vt[i].data));
          check("rx_empty_after_pop", 32'(rx_empty), 32'd1);
        end
        repeat (BIT) @(negedge clk);
      end
    end

    // pop while empty leaves rd_data alone
    read_byte();
    check("rd_hold_when_empty", 32'(rd_data), 32'hA5);

    // 3-tick glitch is a false start
    rx = 1'b0;
    repeat (3 * DVSR) @(negedge clk);
    rx = 1'b1;
    repeat (2 * NB * BIT) @(negedge clk);
    check("glitch_no_push", 32'(rx_empty), 32'd1);

`ifdef UART_PARITY_EN
    got_f = seq_of(frame_of(8'h5A));
    got_f[9] = ~got_f[9];
    drive_rx(got_f);
    repeat (8) @(negedge clk);
    check("parity_err_drop", 32'(rx_empty), 32'd1);
    repeat (BIT) @(negedge clk);
`endif

    // TX fill: 17 fit (one in the FSM), the 18th is dropped
    fork
      begin : fill_wr
        for (int i = 0; i < 17; i++) begin
          @(negedge clk);
          wr_uart = 1'b1;
          w_data  = 8'(i);
        end
        @(negedge clk);
        wr_uart = 1'b0;
        check("tx_full_after_17", 32'(tx_full), 32'd1);
        wr_uart = 1'b1;
        w_data  = 8'h11;
        @(negedge clk);
        wr_uart = 1'b0;
        check("tx_full_hold", 32'(tx_full), 32'd1);
      end
      begin : fill_cap
        for (int k = 0; k < 17; k++) begin
          capture_tx((k == 0) ? 4 * BIT : BIT, got_f, ok_f);
          check("fill_no_gap", 32'(ok_f), 32'd1);
          check("fill_frame", 32'(got_f), 32'(seq_of(frame_of(8'(k)))));
        end
      end
    join
    lows = 0;
    repeat (2 * NB * BIT) begin
      @(negedge clk);
      if (tx == 1'b0) lows++;
    end
    check("fill_no_extra", 32'(lows), 32'd0);
    check("fill_tx_empty", 32'(tx_empty), 32'd1);

    // RX overflow: 0x50 is lost
    for (int i = 0; i < 17; i++) drive_rx(seq_of(frame_of(8'h40 + 8'(i))));
    repeat (8) @(negedge clk);
    check("ovf_rx_full", 32'(rx_full), 32'd1);
    for (int i = 0; i < 16; i++) begin
      read_byte();
      check("ovf_rd", 32'(rd_data), 32'(8'h40 + 8'(i)));
    end
    check("ovf_rx_empty", 32'(rx_empty), 32'd1);

    // reset in the middle of both frames
    write_byte(8'h00);
    repeat (3 * BIT) @(negedge clk);
    rx = 1'b0;
    repeat (4 * BIT) @(negedge clk);
    check("tx_low_before_reset", 32'(tx), 32'd0);
    #2 reset = 1'b0;
    #1;
    check("tx_high_on_reset", 32'(tx), 32'd1);
    check("tx_empty_on_reset", 32'(tx_empty), 32'd1);
    rx = 1'b1;
    #100;
    @(negedge clk);
    reset = 1'b1;
    lows = 0;
    repeat (2 * NB * BIT) begin
      @(negedge clk);
      if (tx == 1'b0) lows++;
    end
    check("abort_tx_idle", 32'(lows), 32'd0);
    check("abort_rx_empty", 32'(rx_empty), 32'd1);
    check("abort_rd_data", 32'(rd_data), 32'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
